// File: rtl/rx_icv_cbc_checker.sv
// Receive-side CAN-SEC ICV checker: CBC-MAC over N 128-bit blocks through a shared
// AES core, then truncated-tag compare against the received ICV.
module rx_icv_cbc_checker #(
    parameter int MAX_BLOCKS  = 16,
    parameter int ICV_BITS    = 64,
    parameter int AES_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                g_rst,
    input  logic                start,
    input  logic [127:0]        iv,
    input  logic [7:0]          num_blocks,
    input  logic                abort,
    input  logic                blk_valid,
    output logic                blk_ready,
    input  logic [127:0]        blk_data,
    output logic                aes_req,
    output logic [127:0]        aes_din,
    input  logic                aes_ack,
    input  logic [127:0]        aes_dout,
    input  logic                icv_valid,
    input  logic [ICV_BITS-1:0] rcvd_icv,
    output logic [ICV_BITS-1:0] icv_out,
    output logic                done,
    output logic                icv_ok,
    output logic                err
);

    localparam int              TW       = $clog2(AES_TIMEOUT) + 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'(AES_TIMEOUT - 1);
    localparam logic [7:0]      MAX_NB   = 8'(MAX_BLOCKS);

    typedef enum logic [2:0] {IDLE, WAIT_BLK, AES_BUSY, WAIT_ICV, CHECK} state_t;

    state_t         state, state_n;
    logic [127:0]   chain;
    logic [7:0]     remaining;
    logic [TW-1:0]  tcnt;

    logic start_ok, start_bad, accept, ack_take, tmo, do_check, kill;

    always_comb begin
        state_n   = state;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        accept    = 1'b0;
        ack_take  = 1'b0;
        tmo       = 1'b0;
        do_check  = 1'b0;
        kill      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_blocks == 8'd0 || num_blocks > MAX_NB) begin
                        start_bad = 1'b1;
                    end else begin
                        start_ok = 1'b1;
                        state_n  = WAIT_BLK;
                    end
                end
            end
            WAIT_BLK: begin
                if (blk_valid && blk_ready) begin
                    accept  = 1'b1;
                    state_n = AES_BUSY;
                end
            end
            AES_BUSY: begin
                // an ack coincident with our own request pulse cannot belong to it
                if (aes_ack && !aes_req) begin
                    ack_take = 1'b1;
                    state_n  = (remaining == 8'd1) ? WAIT_ICV : WAIT_BLK;
                end else if (tcnt == TMO_LAST) begin
                    tmo     = 1'b1;
                    state_n = IDLE;
                end
            end
            WAIT_ICV: begin
                if (icv_valid) state_n = CHECK;
            end
            CHECK: begin
                do_check = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (abort && state != IDLE) begin
            kill     = 1'b1;
            accept   = 1'b0;
            ack_take = 1'b0;
            tmo      = 1'b0;
            do_check = 1'b0;
            state_n  = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (g_rst) begin
            state     <= IDLE;
            chain     <= '0;
            remaining <= '0;
            tcnt      <= '0;
            blk_ready <= 1'b0;
            aes_req   <= 1'b0;
            aes_din   <= '0;
            icv_out   <= '0;
            done      <= 1'b0;
            icv_ok    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state   <= state_n;
            done    <= 1'b0;
            aes_req <= 1'b0;
            if (state == AES_BUSY) tcnt <= tcnt + TW'(1);
            if (start_ok) begin
                chain     <= iv;
                remaining <= num_blocks;
                icv_ok    <= 1'b0;
                err       <= 1'b0;
                blk_ready <= 1'b1;
            end
            if (start_bad) begin
                icv_ok <= 1'b0;
                err    <= 1'b1;
                done   <= 1'b1;
            end
            if (accept) begin
                aes_din   <= chain ^ blk_data;
                aes_req   <= 1'b1;
                blk_ready <= 1'b0;
                tcnt      <= '0;
            end
            if (ack_take) begin
                chain     <= aes_dout;
                remaining <= remaining - 8'd1;
                blk_ready <= (remaining != 8'd1);
            end
            if (tmo) begin
                err  <= 1'b1;
                done <= 1'b1;
            end
            if (do_check) begin
                icv_out <= chain[127 -: ICV_BITS];
                icv_ok  <= (chain[127 -: ICV_BITS] == rcvd_icv);
                done    <= 1'b1;
            end
            if (kill) begin
                chain     <= '0;
                blk_ready <= 1'b0;
                aes_req   <= 1'b0;
                done      <= 1'b0;
                icv_ok    <= 1'b0;
                err       <= 1'b0;
            end
        end
    end

endmodule
